// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// gates the raw write enables so each fires once per instruction, and keeps busy-cycle/retire counters.
module multicycle_sequencer #(
    parameter int WORDSIZE    = 64,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [6:0]           opcode,
    input  logic                 cu_rf_write_en,
    input  logic                 cu_dm_write_en,
    input  logic                 dm_ready,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic                 rf_write_en,
    output logic                 dm_req,
    output logic                 dm_write_en,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_R     = 2'd0,
        CLS_I     = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } op_class_t;

    // The wait counter only has to reach MEM_TIMEOUT-1; the cycle after that is the timeout.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    if (WORDSIZE < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("multicycle_sequencer: WORDSIZE and CNT_WIDTH must be positive");
    end

    state_t                 state_q, state_d;
    op_class_t              op_q, op_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   halt_pending_q, halt_pending_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;

    logic      opcode_legal;
    op_class_t opcode_class;
    logic      is_store;
    logic      is_mem;
    logic      mem_done;
    state_t    retire_next;

    always_comb begin
        opcode_legal = 1'b1;
        opcode_class = CLS_R;
        case (opcode)
            7'b0110011: opcode_class = CLS_R;
            7'b0010011: opcode_class = CLS_I;
            7'b0000011: opcode_class = CLS_LOAD;
            7'b0100011: opcode_class = CLS_STORE;
            default:    opcode_legal = 1'b0;
        endcase
    end

    assign is_store = (op_q == CLS_STORE);
    assign is_mem   = (op_q == CLS_LOAD) || (op_q == CLS_STORE);
    assign mem_done = (state_q == S_MEMORY) && dm_ready;

    // Moore outputs from state_q; the store completion terms also look at dm_ready.
    assign state         = state_q;
    assign ir_load       = (state_q == S_FETCH);
    assign dm_req        = (state_q == S_MEMORY);
    assign rf_write_en   = (state_q == S_WRITEBACK) && cu_rf_write_en;
    assign dm_write_en   = mem_done && is_store && cu_dm_write_en;
    assign pc_en         = (state_q == S_WRITEBACK) || (mem_done && is_store);
    assign busy          = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
    assign halted        = (state_q == S_HALT);
    assign error         = (state_q == S_ERROR);
    assign cycle_count   = cycle_q;
    assign instr_retired = retired_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        wait_d         = wait_q;
        halt_pending_d = halt_pending_q | halt_req;
        // A halt request raised in the retire cycle itself still stops at this boundary.
        retire_next    = (halt_pending_q || halt_req) ? S_HALT : S_FETCH;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode_legal) begin
                    op_d    = opcode_class;
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_EXECUTE: begin
                wait_d  = '0;
                state_d = is_mem ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dm_ready) begin
                    state_d = is_store ? retire_next : S_WRITEBACK;
                end else if (MEM_TIMEOUT > 0 && wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: state_d = retire_next;
            default: state_d = state_q;
        endcase

        cycle_d   = busy  ? cycle_q + 1'b1   : cycle_q;
        retired_d = pc_en ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= CLS_R;
            wait_q         <= '0;
            halt_pending_q <= 1'b0;
            cycle_q        <= '0;
            retired_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            wait_q         <= wait_d;
            halt_pending_q <= halt_pending_d;
            cycle_q        <= cycle_d;
            retired_q      <= retired_d;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction is expanded into its expected per-cycle state schedule
// from the latency rules, then driven and checked cycle by cycle against a small counter/halt model.
module tb_multicycle_sequencer;

    localparam int CW = 4;
    localparam int TO = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          halt_req;
    logic [6:0]    opcode;
    logic          cu_rf_write_en;
    logic          cu_dm_write_en;
    logic          dm_ready;
    logic          ir_load;
    logic          pc_en;
    logic          rf_write_en;
    logic          dm_req;
    logic          dm_write_en;
    logic          busy;
    logic          halted;
    logic          error;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instr_retired;

    int errors = 0;
    int checks = 0;
    int exp_cycles = 0;
    int exp_retired = 0;
    bit halt_pend = 1'b0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .WORDSIZE(64),
        .CNT_WIDTH(CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .halt_req(halt_req),
        .opcode(opcode),
        .cu_rf_write_en(cu_rf_write_en),
        .cu_dm_write_en(cu_dm_write_en),
        .dm_ready(dm_ready),
        .ir_load(ir_load),
        .pc_en(pc_en),
        .rf_write_en(rf_write_en),
        .dm_req(dm_req),
        .dm_write_en(dm_write_en),
        .busy(busy),
        .halted(halted),
        .error(error),
        .state(state),
        .cycle_count(cycle_count),
        .instr_retired(instr_retired)
    );

    function automatic bit is_legal(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_LOAD) || (o == OP_STORE);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle with inputs already applied: check outputs at the falling edge, then advance the model.
    task automatic cyc(input logic [2:0] s, input bit is_st);
        bit e_busy, e_pc, e_rf, e_dmw;
        @(negedge clk);
        e_busy = (s >= 3'd1) && (s <= 3'd5);
        e_pc   = (s == 3'd5) || (s == 3'd4 && is_st && dm_ready);
        e_rf   = (s == 3'd5) && cu_rf_write_en;
        e_dmw  = (s == 3'd4) && is_st && dm_ready && cu_dm_write_en;
        check("state", 32'(state), 32'(s));
        check("ir_load", 32'(ir_load), 32'(s == 3'd1));
        check("dm_req", 32'(dm_req), 32'(s == 3'd4));
        check("pc_en", 32'(pc_en), 32'(e_pc));
        check("rf_write_en", 32'(rf_write_en), 32'(e_rf));
        check("dm_write_en", 32'(dm_write_en), 32'(e_dmw));
        check("busy", 32'(busy), 32'(e_busy));
        check("halted", 32'(halted), 32'(s == 3'd6));
        check("error", 32'(error), 32'(s == 3'd7));
        check("cycle_count", 32'(cycle_count), 32'(exp_cycles % (1 << CW)));
        check("instr_retired", 32'(instr_retired), 32'(exp_retired % (1 << CW)));
        @(posedge clk);
        if (!rst_n) begin
            exp_cycles  = 0;
            exp_retired = 0;
            halt_pend   = 1'b0;
        end else begin
            if (halt_req) halt_pend = 1'b1;
            if (e_busy) exp_cycles++;
            if (e_pc) exp_retired++;
        end
        #1;
    endtask

    task automatic hold(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            start          = (s == 3'd0) ? 1'b0 : 1'($urandom_range(0, 1));
            halt_req       = (s >= 3'd6) ? 1'($urandom_range(0, 1)) : 1'b0;
            dm_ready       = 1'($urandom_range(0, 1));
            cu_rf_write_en = 1'($urandom_range(0, 1));
            cu_dm_write_en = 1'($urandom_range(0, 1));
            opcode         = 7'($urandom);
            cyc(s, 1'b0);
        end
        halt_req = 1'b0;
    endtask

    task automatic do_reset(input logic [2:0] cur);
        rst_n    = 1'b0;
        start    = 1'($urandom_range(0, 1));
        halt_req = 1'b0;
        dm_ready = 1'b0;
        cyc(cur, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic begin_run(input bit with_halt);
        hold(3'd0, 1);
        start    = 1'b1;
        halt_req = with_halt;
        dm_ready = 1'($urandom_range(0, 1));
        cyc(3'd0, 1'b0);
        start    = 1'b0;
        halt_req = 1'b0;
    endtask

    // outcome: 0 retired, 1 went to ERROR, 2 reset applied during MEMORY.
    task automatic run_instr(input logic [6:0] opc, input int waits, input int halt_at,
                             input int rst_mem, input bit we_hi, output int outcome);
        bit ld, st, mem;
        int idx, midx, n;
        logic [2:0] s;
        ld  = (opc == OP_LOAD);
        st  = (opc == OP_STORE);
        mem = ld || st;
        exp_q.delete();
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        outcome = 0;
        if (!is_legal(opc)) begin
            outcome = 1;
        end else begin
            exp_q.push_back(3'd3);
            if (mem) begin
                n = (waits < TO) ? waits + 1 : TO;
                for (int k = 0; k < n; k++) exp_q.push_back(3'd4);
                if (waits >= TO) outcome = 1;
                else if (ld) exp_q.push_back(3'd5);
            end else begin
                exp_q.push_back(3'd5);
            end
        end
        idx  = 0;
        midx = 0;
        while (exp_q.size() > 0) begin
            s              = exp_q.pop_front();
            opcode         = opc;
            start          = 1'($urandom_range(0, 1));
            halt_req       = (idx == halt_at);
            cu_rf_write_en = we_hi ? 1'b1 : 1'($urandom_range(0, 1));
            cu_dm_write_en = we_hi ? 1'b1 : 1'($urandom_range(0, 1));
            if (s == 3'd4) begin
                dm_ready = (midx == waits);
                if (midx == rst_mem) begin
                    rst_n    = 1'b0;
                    dm_ready = 1'b0;
                end
                midx++;
            end else begin
                dm_ready = 1'($urandom_range(0, 1));
            end
            cyc(s, st);
            if (!rst_n) begin
                rst_n    = 1'b1;
                halt_req = 1'b0;
                outcome  = 2;
                return;
            end
            idx++;
        end
        halt_req = 1'b0;
    endtask

    initial begin
        int oc;
        int last;
        logic [6:0] legal_ops[4];
        logic [6:0] bad;
        legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE};
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; opcode = '0;
        cu_rf_write_en = 1'b0; cu_dm_write_en = 1'b0; dm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type, write enable high throughout
        begin_run(1'b0);
        run_instr(OP_R, 0, -1, -1, 1'b1, oc);
        check("t1_outcome", 32'(oc), 32'd0);
        do_reset(3'd1);

        // LOAD, ready on 3rd MEMORY cycle: 7 busy cycles
        begin_run(1'b0);
        run_instr(OP_LOAD, 2, -1, -1, 1'b1, oc);
        do_reset(3'd1);

        // STORE, ready on 2nd MEMORY cycle
        begin_run(1'b0);
        run_instr(OP_STORE, 1, -1, -1, 1'b1, oc);
        do_reset(3'd1);

        // Illegal opcode: ERROR holds until reset
        begin_run(1'b0);
        run_instr(7'b1111111, 0, -1, -1, 1'b0, oc);
        check("t4_outcome", 32'(oc), 32'd1);
        hold(3'd7, 5);
        do_reset(3'd7);
        hold(3'd0, 2);

        // Halt request during EXECUTE of an R-type
        begin_run(1'b0);
        run_instr(OP_R, 0, 2, -1, 1'b0, oc);
        check("t5_halt_pending", 32'(halt_pend), 32'd1);
        hold(3'd6, 6);
        do_reset(3'd6);

        // start and halt_req together in IDLE: one instruction then HALT
        begin_run(1'b1);
        run_instr(OP_I, 0, -1, -1, 1'b0, oc);
        hold(3'd6, 3);
        do_reset(3'd6);

        // LOAD and STORE memory timeouts
        begin_run(1'b0);
        run_instr(OP_LOAD, 99, -1, -1, 1'b0, oc);
        check("t6_load_timeout", 32'(oc), 32'd1);
        hold(3'd7, 3);
        do_reset(3'd7);
        begin_run(1'b0);
        run_instr(OP_STORE, 99, -1, -1, 1'b1, oc);
        hold(3'd7, 2);
        do_reset(3'd7);

        // Reset in 2nd MEMORY cycle drops the request
        begin_run(1'b0);
        run_instr(OP_LOAD, 99, -1, 1, 1'b0, oc);
        check("t6_reset_mid_mem", 32'(oc), 32'd2);
        hold(3'd0, 3);

        // Random back-to-back stream; counters wrap several times, last instruction requests a halt
        begin_run(1'b0);
        for (int i = 0; i < 60; i++) begin
            last = (i == 59) ? int'($urandom_range(0, 3)) : -1;
            run_instr(legal_ops[$urandom_range(0, 3)], int'($urandom_range(0, 3)), last, -1, 1'b0, oc);
        end
        hold(3'd6, 3);
        do_reset(3'd6);

        // Random illegal opcode
        do bad = 7'($urandom); while (is_legal(bad));
        begin_run(1'b0);
        run_instr(OP_STORE, int'($urandom_range(0, 3)), -1, -1, 1'b0, oc);
        run_instr(bad, 0, -1, -1, 1'b0, oc);
        hold(3'd7, 3);
        do_reset(3'd7);
        hold(3'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
